// File: rtl/bus_pkg.sv
// Shared types for the round-robin simple-bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping modulo N.
module rr_picker #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any_req
);

  localparam int unsigned IW = $clog2(N);

  logic found;

  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned j;
      j = (32'(ptr) + k) % N;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one simple-bus segment among N_MASTERS requesters,
// one outstanding transaction at a time, with a DECERR timeout for unanswered requests.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS-1:0]          m_wr_en,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  output logic [N_MASTERS-1:0]          m_ready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [1:0]                    m_resp,
  output logic                          bus_valid,
  output logic [ADDR_W-1:0]             bus_addr,
  output logic                          bus_wr_en,
  output logic [DATA_W-1:0]             bus_wdata,
  input  logic                          bus_ready,
  input  logic [DATA_W-1:0]             bus_rdata,
  input  logic [1:0]                    bus_resp
);

  localparam int unsigned IW = $clog2(N_MASTERS);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  arb_state_t            state_q, state_d;
  logic [IW-1:0]         gnt_q, gnt_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [N_MASTERS-1:0]  m_ready_q, m_ready_d;
  logic [DATA_W-1:0]     m_rdata_q, m_rdata_d;
  logic [1:0]            m_resp_q, m_resp_d;
  logic                  bus_valid_q, bus_valid_d;
  logic [ADDR_W-1:0]     bus_addr_q, bus_addr_d;
  logic                  bus_wr_en_q, bus_wr_en_d;
  logic [DATA_W-1:0]     bus_wdata_q, bus_wdata_d;

  logic [IW-1:0]         pick_idx;
  logic                  any_req;

  rr_picker #(
    .N (N_MASTERS)
  ) u_picker (
    .req     (m_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .any_req (any_req)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    m_ready_d   = m_ready_q;
    m_rdata_d   = m_rdata_q;
    m_resp_d    = m_resp_q;
    bus_valid_d = bus_valid_q;
    bus_addr_d  = bus_addr_q;
    bus_wr_en_d = bus_wr_en_q;
    bus_wdata_d = bus_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d       = pick_idx;
          bus_addr_d  = m_addr[pick_idx*ADDR_W +: ADDR_W];
          bus_wr_en_d = m_wr_en[pick_idx];
          bus_wdata_d = m_wdata[pick_idx*DATA_W +: DATA_W];
          bus_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A slave answer on the timeout cycle still wins over DECERR.
        if (bus_ready) begin
          m_rdata_d          = bus_wr_en_q ? '0 : bus_rdata;
          m_resp_d           = bus_resp;
          m_ready_d          = '0;
          m_ready_d[gnt_q]   = 1'b1;
          bus_valid_d        = 1'b0;
          state_d            = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          m_rdata_d          = '0;
          m_resp_d           = DECERR;
          m_ready_d          = '0;
          m_ready_d[gnt_q]   = 1'b1;
          bus_valid_d        = 1'b0;
          state_d            = DONE;
        end
      end
      DONE: begin
        m_ready_d = '0;
        rr_ptr_d  = (gnt_q == IW'(N_MASTERS - 1)) ? '0 : gnt_q + IW'(1);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      m_ready_q   <= '0;
      m_rdata_q   <= '0;
      m_resp_q    <= OKAY;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_wr_en_q <= 1'b0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      m_ready_q   <= m_ready_d;
      m_rdata_q   <= m_rdata_d;
      m_resp_q    <= m_resp_d;
      bus_valid_q <= bus_valid_d;
      bus_addr_q  <= bus_addr_d;
      bus_wr_en_q <= bus_wr_en_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign m_ready   = m_ready_q;
  assign m_rdata   = m_rdata_q;
  assign m_resp    = m_resp_q;
  assign bus_valid = bus_valid_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wr_en = bus_wr_en_q;
  assign bus_wdata = bus_wdata_q;

endmodule
